sr_cmd_debouncer: RTL and testbench

Upstream command stage for the SR flip-flop: takes two raw, possibly bouncy level inputs (set request, clear request), debounces each, and converts debounced rising edges into clean one-cycle S and R pulses. It guarantees S and R are never high together and enforces a hold-off gap between commands. Its S/R outputs drive the flip-flop's S/R inputs directly on the same clk.

---
 rtl/sr_cmd_pkg.sv | 20 ++
 rtl/debounce_ch.sv | 54 +++++
 rtl/sr_cmd_debouncer.sv | 147 ++++++++++++++
 tb/tb_sr_cmd_debouncer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sr_cmd_pkg.sv
// Shared types and defaults for the SR command debouncer: FSM state encoding,
// default timing constants and a counter-width helper.
package sr_cmd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPulseS,
        StPulseR,
        StHoldoff
    } sr_cmd_state_e;

    localparam int unsigned DefDebounceCycles = 4;
    localparam int unsigned DefHoldoffCycles  = 2;

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: a raw level must hold a new value for DEBOUNCE_CYCLES
// consecutive samples before the debounced level follows; emits a registered
// one-cycle pulse on each debounced 0->1 transition.
module debounce_ch
    import sr_cmd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (raw == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            // Final differing sample: this one completes the run.
            level_d = raw;
            cnt_d   = '0;
            rise_d  = raw;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/sr_cmd_debouncer.sv
// Debounces raw set/clear requests into mutually exclusive one-cycle S/R pulses
// with a hold-off gap. Define SR_CMD_SYNC_EN to add two-flop input synchronizers.
module sr_cmd_debouncer
    import sr_cmd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned HOLDOFF_CYCLES  = DefHoldoffCycles
) (
    input  logic clk,
    input  logic rst,
    input  logic set_in,
    input  logic clr_in,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict,
    output logic dropped
);

    localparam int unsigned HoldW = cnt_width(HOLDOFF_CYCLES);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLDOFF_CYCLES - 1);

    logic set_src, clr_src;

`ifdef SR_CMD_SYNC_EN
    logic [1:0] set_sync_q, clr_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            set_sync_q <= '0;
            clr_sync_q <= '0;
        end else begin
            set_sync_q <= {set_sync_q[0], set_in};
            clr_sync_q <= {clr_sync_q[0], clr_in};
        end
    end

    assign set_src = set_sync_q[1];
    assign clr_src = clr_sync_q[1];
`else
    assign set_src = set_in;
    assign clr_src = clr_in;
`endif

    logic set_level, set_rise;
    logic clr_level, clr_rise;

    debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_set_ch (
        .clk  (clk),
        .rst  (rst),
        .raw  (set_src),
        .level(set_level),
        .rise (set_rise)
    );

    debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clr_ch (
        .clk  (clk),
        .rst  (rst),
        .raw  (clr_src),
        .level(clr_level),
        .rise (clr_rise)
    );

    // Debounced levels are only needed for observation inside the channels.
    logic unused_levels;
    assign unused_levels = set_level ^ clr_level;

    sr_cmd_state_e   state_q, state_d;
    logic [HoldW-1:0] hcnt_q, hcnt_d;
    logic            s_q, s_d;
    logic            r_q, r_d;
    logic            busy_q, busy_d;
    logic            conflict_q, conflict_d;
    logic            dropped_q, dropped_d;

    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        s_d        = 1'b0;
        r_d        = 1'b0;
        conflict_d = 1'b0;
        dropped_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (set_rise && clr_rise) begin
                    conflict_d = 1'b1;
                end else if (set_rise) begin
                    state_d = StPulseS;
                    s_d     = 1'b1;
                end else if (clr_rise) begin
                    state_d = StPulseR;
                    r_d     = 1'b1;
                end
            end
            StPulseS, StPulseR: begin
                dropped_d = set_rise | clr_rise;
                state_d   = StHoldoff;
                hcnt_d    = '0;
            end
            StHoldoff: begin
                dropped_d = set_rise | clr_rise;
                if (hcnt_q == HoldMax) begin
                    state_d = StIdle;
                    hcnt_d  = '0;
                end else begin
                    hcnt_d = hcnt_q + HoldW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                hcnt_d  = '0;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            hcnt_q     <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
            dropped_q  <= dropped_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Directed bench for sr_cmd_debouncer: per-window event counts and first-cycle
// indices checked against hand-derived timing (SR_CMD_SYNC_EN adds 2 cycles).
module tb_sr_cmd_debouncer;

`ifdef SR_CMD_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic clk = 1'b0;
    logic rst, set_in, clr_in;
    logic S, R, busy, conflict, dropped;

    always #5 clk = ~clk;

    sr_cmd_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .HOLDOFF_CYCLES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .set_in  (set_in),
        .clr_in  (clr_in),
        .S       (S),
        .R       (R),
        .busy    (busy),
        .conflict(conflict),
        .dropped (dropped)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int e;
    int s_cnt, r_cnt, busy_cnt, conf_cnt, drop_cnt;
    int s_first, r_first, busy_first, conf_first, drop_first;
    int both_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        e = 0;
        s_cnt = 0; r_cnt = 0; busy_cnt = 0; conf_cnt = 0; drop_cnt = 0;
        s_first = 0; r_first = 0; busy_first = 0; conf_first = 0; drop_first = 0;
    endtask

    // Advance n edges; outputs sampled 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e++;
            if (S === 1'b1) begin s_cnt++; if (s_first == 0) s_first = e; end
            if (R === 1'b1) begin r_cnt++; if (r_first == 0) r_first = e; end
            if (busy === 1'b1) begin busy_cnt++; if (busy_first == 0) busy_first = e; end
            if (conflict === 1'b1) begin conf_cnt++; if (conf_first == 0) conf_first = e; end
            if (dropped === 1'b1) begin drop_cnt++; if (drop_first == 0) drop_first = e; end
            if (S === 1'b1 && R === 1'b1) both_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; set_in = 1'b1; clr_in = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with set_in high: everything quiet
        clear_stats();
        step(2);
        check_eq("rst_s", s_cnt, 0);
        check_eq("rst_r", r_cnt, 0);
        check_eq("rst_busy", busy_cnt, 0);
        check_eq("rst_conflict", conf_cnt, 0);
        check_eq("rst_dropped", drop_cnt, 0);

        // Release: held set_in debounced from scratch
        rst = 1'b0;
        clear_stats();
        step(12);
        check_eq("post_rst_s_cnt", s_cnt, 1);
        check_eq("post_rst_s_first", s_first, 5 + L);
        check_eq("post_rst_busy_cnt", busy_cnt, 3);
        check_eq("post_rst_r_cnt", r_cnt, 0);

        // Falling edge is silent
        set_in = 1'b0;
        clear_stats();
        step(10);
        check_eq("fall_s_cnt", s_cnt, 0);
        check_eq("fall_busy_cnt", busy_cnt, 0);

        // Clean set
        clear_stats();
        set_in = 1'b1;
        step(12);
        check_eq("set_s_cnt", s_cnt, 1);
        check_eq("set_s_first", s_first, 5 + L);
        check_eq("set_busy_cnt", busy_cnt, 3);
        check_eq("set_busy_first", busy_first, 5 + L);
        check_eq("set_r_cnt", r_cnt, 0);
        set_in = 1'b0;
        step(10);

        // Bounce on clr: 3 high, 1 low, 3 high, low
        clear_stats();
        clr_in = 1'b1; step(3);
        clr_in = 1'b0; step(1);
        clr_in = 1'b1; step(3);
        clr_in = 1'b0; step(8);
        check_eq("bounce_r_cnt", r_cnt, 0);
        check_eq("bounce_busy_cnt", busy_cnt, 0);

        // Held exactly 4 samples: one R pulse
        clear_stats();
        clr_in = 1'b1; step(4);
        clr_in = 1'b0; step(14);
        check_eq("clr_r_cnt", r_cnt, 1);
        check_eq("clr_r_first", r_first, 5 + L);
        check_eq("clr_s_cnt", s_cnt, 0);

        // Conflict: both rise on the same edge
        clear_stats();
        set_in = 1'b1; clr_in = 1'b1;
        step(12);
        check_eq("conf_cnt", conf_cnt, 1);
        check_eq("conf_first", conf_first, 5 + L);
        check_eq("conf_s_cnt", s_cnt, 0);
        check_eq("conf_r_cnt", r_cnt, 0);
        check_eq("conf_busy_cnt", busy_cnt, 0);
        set_in = 1'b0; clr_in = 1'b0;
        step(10);

        // Hold-off drop: clr debounces while the S command is in hold-off
        clear_stats();
        set_in = 1'b1; step(2);
        clr_in = 1'b1; step(14);
        check_eq("drop_s_cnt", s_cnt, 1);
        check_eq("drop_s_first", s_first, 5 + L);
        check_eq("drop_cnt", drop_cnt, 1);
        check_eq("drop_first", drop_first, 7 + L);
        check_eq("drop_r_cnt", r_cnt, 0);
        set_in = 1'b0; clr_in = 1'b0;
        step(10);
        clear_stats();
        clr_in = 1'b1; step(10);
        check_eq("after_drop_r_cnt", r_cnt, 1);
        check_eq("after_drop_r_first", r_first, 5 + L);
        check_eq("after_drop_dropped", drop_cnt, 0);
        clr_in = 1'b0; step(10);

        // Reset in the PULSE_S cycle
        clear_stats();
        set_in = 1'b1;
        step(5 + L);
        check_eq("mid_s_high", S, 1);
        rst = 1'b1;
        step(1);
        check_eq("mid_rst_s", S, 0);
        check_eq("mid_rst_busy", busy, 0);
        rst = 1'b0;
        clear_stats();
        step(12);
        check_eq("mid_refire_s_cnt", s_cnt, 1);
        check_eq("mid_refire_s_first", s_first, 5 + L);
        set_in = 1'b0;
        step(10);

        check_eq("s_and_r_never", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
